// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack
// read bus and presents {pc, instruction} to the IF/ID register.
module pc_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_hold_flag,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_pc_addr,
    output logic [DATA_W-1:0] o_inst_data,
    output logic              o_inst_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUF
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic              r_req;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_kill;
    logic [ADDR_W-1:0] r_out_pc;
    logic [DATA_W-1:0] r_out_inst;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_buf_data;
    logic [ADDR_W-1:0] r_buf_pc;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_kill_nxt;
    logic [ADDR_W-1:0] w_out_pc_nxt;
    logic [DATA_W-1:0] w_out_inst_nxt;
    logic              w_out_valid_nxt;
    logic [DATA_W-1:0] w_buf_data_nxt;
    logic [ADDR_W-1:0] w_buf_pc_nxt;

    logic              w_ack;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_jump_pc;

    // An ack only counts while a request is actually on the bus.
    assign w_ack     = i_mem_ack & r_req;
    assign w_pc_inc  = r_pc + ADDR_W'(4);
    assign w_jump_pc = {i_jump_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (!i_jump_flag && w_ack && !r_kill && i_hold_flag) begin
                    w_state_nxt = S_BUF;
                end
            end
            S_BUF: begin
                if (i_jump_flag || !i_hold_flag) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt        = r_pc;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_req_addr;
        w_kill_nxt      = r_kill;
        w_out_pc_nxt    = r_out_pc;
        w_out_inst_nxt  = r_out_inst;
        w_out_valid_nxt = r_out_valid;
        w_buf_data_nxt  = r_buf_data;
        w_buf_pc_nxt    = r_buf_pc;
        if (i_jump_flag) begin
            w_pc_nxt        = w_jump_pc;
            w_out_inst_nxt  = NOP_INST;
            w_out_valid_nxt = 1'b0;
            w_req_nxt       = 1'b1;
            // An unanswered request must finish on its old address first.
            w_kill_nxt      = r_req & ~w_ack;
            if (!(r_req && !w_ack)) begin
                w_addr_nxt = w_jump_pc;
            end
        end else begin
            if (!i_hold_flag) begin
                w_out_inst_nxt  = NOP_INST;
                w_out_valid_nxt = 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_pc;
                end
                S_REQ: begin
                    if (w_ack && r_kill) begin
                        w_kill_nxt = 1'b0;
                        w_addr_nxt = r_pc;
                    end else if (w_ack && i_hold_flag) begin
                        w_buf_data_nxt = i_mem_rdata;
                        w_buf_pc_nxt   = r_pc;
                        w_pc_nxt       = w_pc_inc;
                        w_req_nxt      = 1'b0;
                    end else if (w_ack) begin
                        w_out_pc_nxt    = r_pc;
                        w_out_inst_nxt  = i_mem_rdata;
                        w_out_valid_nxt = 1'b1;
                        w_pc_nxt        = w_pc_inc;
                        w_addr_nxt      = w_pc_inc;
                    end
                end
                S_BUF: begin
                    if (!i_hold_flag) begin
                        w_out_pc_nxt    = r_buf_pc;
                        w_out_inst_nxt  = r_buf_data;
                        w_out_valid_nxt = 1'b1;
                        w_req_nxt       = 1'b1;
                        w_addr_nxt      = r_pc;
                    end
                end
                default: w_req_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_kill      <= 1'b0;
            r_out_pc    <= RESET_PC;
            r_out_inst  <= NOP_INST;
            r_out_valid <= 1'b0;
            r_buf_data  <= NOP_INST;
            r_buf_pc    <= RESET_PC;
        end else begin
            r_pc        <= w_pc_nxt;
            r_req       <= w_req_nxt;
            r_req_addr  <= w_addr_nxt;
            r_kill      <= w_kill_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_buf_data  <= w_buf_data_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
        end
    end

    assign o_mem_req    = r_req;
    assign o_mem_addr   = r_req_addr;
    assign o_pc_addr    = r_out_pc;
    assign o_inst_data  = r_out_inst;
    assign o_inst_valid = r_out_valid;

endmodule
